// File: rtl/mac_unit.sv
// mac_unit: two-stage pipelined multiply / 4-lane dot product / complex multiply
// with valid/ready handshakes on both sides.
// Optional feature: define MAC_UNIT_ACC_EN to compile in a 2W-bit running
// accumulator; without it in_acc is ignored and out_data is the raw result.
module mac_unit #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_op,
  input  logic           in_sgn,
  input  logic           in_conj,
  input  logic           in_acc,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_data,
  output logic           out_err
);
  localparam int L  = W / 4;
  localparam int H  = W / 2;
  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DOT4 = 2'b01,
    OP_CMUL = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  logic                 s1_valid;
  op_e                  s1_op;
  logic                 s1_conj;
  logic [3:0][W2-1:0]   s1_p;
  logic                 s2_valid;
  logic [W2-1:0]        s2_data;
  logic                 s2_err;
  logic                 s2_accept;

  // S2 can take new data when it is empty or its result leaves this cycle;
  // in_ready therefore depends combinationally on out_ready.
  assign s2_accept = !s2_valid || out_ready;
  assign in_ready  = !rst && (!s1_valid || s2_accept);

  // Full-width MUL operands, sign- or zero-extended so one 2W multiply covers both modes.
  logic [W2-1:0] mul_a, mul_b;
  assign mul_a = in_sgn ? {{W{in_a[W-1]}}, in_a} : {{W{1'b0}}, in_a};
  assign mul_b = in_sgn ? {{W{in_b[W-1]}}, in_b} : {{W{1'b0}}, in_b};

  // DOT4 lane products, each exact in 2L bits and then extended to 2W.
  logic [3:0][W2-1:0] lane_prod;
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [2*L-1:0] lane_a, lane_b, lane_p;
    assign lane_a = in_sgn ? {{L{in_a[k*L+L-1]}}, in_a[k*L +: L]} : {{L{1'b0}}, in_a[k*L +: L]};
    assign lane_b = in_sgn ? {{L{in_b[k*L+L-1]}}, in_b[k*L +: L]} : {{L{1'b0}}, in_b[k*L +: L]};
    assign lane_p = lane_a * lane_b;
    assign lane_prod[k] = in_sgn ? {{(W2-2*L){lane_p[2*L-1]}}, lane_p}
                                 : {{(W2-2*L){1'b0}}, lane_p};
  end

  // CMUL halves are always two's complement; W-bit products suffice since re/im wrap mod 2^W.
  logic [W-1:0] ar_x, ai_x, br_x, bi_x;
  assign ar_x = {{H{in_a[W-1]}}, in_a[W-1:H]};
  assign ai_x = {{H{in_a[H-1]}}, in_a[H-1:0]};
  assign br_x = {{H{in_b[W-1]}}, in_b[W-1:H]};
  assign bi_x = {{H{in_b[H-1]}}, in_b[H-1:0]};

  logic [3:0][W2-1:0] s1_in;

  // Select the partial products S1 captures for the requested operation.
  always_comb begin
    s1_in = '0;
    case (op_e'(in_op))
      OP_MUL:  s1_in[0] = mul_a * mul_b;
      OP_DOT4: s1_in = lane_prod;
      OP_CMUL: begin
        s1_in[0] = {{W{1'b0}}, ar_x * br_x};
        s1_in[1] = {{W{1'b0}}, ai_x * bi_x};
        s1_in[2] = {{W{1'b0}}, ar_x * bi_x};
        s1_in[3] = {{W{1'b0}}, ai_x * br_x};
      end
      default: s1_in = '0;
    endcase
  end

  logic [W2-1:0] res;
  logic          res_err;
  logic [W-1:0]  cm_re, cm_im;

  // Combine the S1 partial products into the final result for S2.
  always_comb begin
    cm_re   = s1_conj ? s1_p[0][W-1:0] + s1_p[1][W-1:0] : s1_p[0][W-1:0] - s1_p[1][W-1:0];
    cm_im   = s1_conj ? s1_p[3][W-1:0] - s1_p[2][W-1:0] : s1_p[2][W-1:0] + s1_p[3][W-1:0];
    res     = '0;
    res_err = 1'b0;
    case (s1_op)
      OP_MUL:  res = s1_p[0];
      OP_DOT4: res = s1_p[0] + s1_p[1] + s1_p[2] + s1_p[3];
      OP_CMUL: res = {cm_re, cm_im};
      default: res_err = 1'b1;
    endcase
  end

  logic [W2-1:0] s2_next;

`ifdef MAC_UNIT_ACC_EN
  logic          s1_acc;
  logic [W2-1:0] acc, acc_base;

  // New accumulator value; CMUL halves accumulate independently, reserved ops output zero.
  always_comb begin
    acc_base = s1_acc ? acc : '0;
    s2_next  = acc_base + res;
    if (s1_op == OP_CMUL)
      s2_next = {acc_base[W2-1:W] + res[W2-1:W], acc_base[W-1:0] + res[W-1:0]};
    if (res_err)
      s2_next = '0;
  end

  // Accumulator updates once per transaction as it moves S1 -> S2; reserved ops leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      s1_acc <= 1'b0;
    end else begin
      if (s2_accept && s1_valid && !res_err)
        acc <= s2_next;
      if (in_ready && in_valid)
        s1_acc <= in_acc;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = in_acc;
  assign s2_next    = res;
`endif

  // Two-stage pipeline: S1 holds partial products, S2 holds the outgoing result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MUL;
      s1_conj  <= 1'b0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (s2_accept) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s2_next;
          s2_err  <= res_err;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op   <= op_e'(in_op);
          s1_conj <= in_conj;
          s1_p    <= s1_in;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_err   = s2_err;

endmodule
